// File: rtl/shared_buffer_vc_lists_if.sv
// rtl/shared_buffer_vc_lists_if.sv - push/pop/tracker signal bundle for shared_buffer_vc_lists
interface shared_buffer_vc_lists_if #(
   parameter int memory_bank_depth = 32,
   parameter int memory_bank_width = 64,
   parameter int num_vcs           = 4
);
   localparam int memory_addr_width = $clog2(memory_bank_depth);
   localparam int vc_idx_width      = $clog2(num_vcs);

   logic                         push_valid;
   logic [vc_idx_width-1:0]      push_vc;
   logic [memory_bank_width-1:0] push_data;
   logic                         push_ready;
   logic                         pop_valid;
   logic [vc_idx_width-1:0]      pop_vc;
   logic [memory_bank_width-1:0] pop_data;
   logic                         pop_data_valid;
   logic [num_vcs-1:0]           vc_empty;
   logic [memory_addr_width-1:0] alloc_slot;
   logic                         free_list_empty;
   logic                         free_list_full;
   logic                         alloc_enable;
   logic                         free_enable;
   logic [memory_addr_width-1:0] freed_slot;

   modport slave (
      input  push_valid, push_vc, push_data, pop_valid, pop_vc,
             alloc_slot, free_list_empty, free_list_full,
      output push_ready, pop_data, pop_data_valid, vc_empty,
             alloc_enable, free_enable, freed_slot
   );

   modport master (
      output push_valid, push_vc, push_data, pop_valid, pop_vc,
             alloc_slot, free_list_empty, free_list_full,
      input  push_ready, pop_data, pop_data_valid, vc_empty,
             alloc_enable, free_enable, freed_slot
   );
endinterface

// File: rtl/shared_buffer_vc_lists.sv
// rtl/shared_buffer_vc_lists.sv - per-VC linked lists over a shared flit buffer fed by a free-slot tracker
module shared_buffer_vc_lists #(
   parameter int memory_bank_depth = 32,
   parameter int memory_bank_width = 64,
   parameter int num_vcs           = 4
) (
   input logic                    clk,
   input logic                    reset,
   shared_buffer_vc_lists_if.slave bus
);
   localparam int memory_addr_width = $clog2(memory_bank_depth);
   localparam int vc_idx_width      = $clog2(num_vcs);
   localparam int count_width       = memory_addr_width + 1;

   logic [memory_addr_width-1:0] r_head [num_vcs];
   logic [memory_addr_width-1:0] r_tail [num_vcs];
   logic [count_width-1:0]       r_count [num_vcs];
   logic [memory_bank_width-1:0] r_data_ram [memory_bank_depth];
   logic [memory_addr_width-1:0] r_next_ram [memory_bank_depth];
   logic [memory_bank_width-1:0] r_pop_data;
   logic                         r_pop_data_valid;

   logic                         w_push_acc;
   logic                         w_pop_acc;
   logic                         w_link;
   logic [memory_addr_width-1:0] w_pop_head;
   logic [num_vcs-1:0]           w_push_hit;
   logic [num_vcs-1:0]           w_pop_hit;
   logic [num_vcs-1:0]           w_vc_empty;
   logic                         w_unused_ok;

   always_comb begin
      w_vc_empty = '0;
      w_push_hit = '0;
      w_pop_hit  = '0;
      for (int v = 0; v < num_vcs; v++) begin
         w_vc_empty[v] = (r_count[v] == '0);
      end
      w_push_acc = bus.push_valid && !bus.free_list_empty;
      w_pop_acc  = bus.pop_valid && !w_vc_empty[bus.pop_vc];
      w_pop_head = r_head[bus.pop_vc];
      for (int v = 0; v < num_vcs; v++) begin
         w_push_hit[v] = w_push_acc && (bus.push_vc == vc_idx_width'(v));
         w_pop_hit[v]  = w_pop_acc  && (bus.pop_vc  == vc_idx_width'(v));
      end
      // Append behind the old tail only if the list is still non-empty after this cycle's pop;
      // otherwise the new slot becomes head and tail directly (covers the count==1 bypass).
      w_link = w_push_acc &&
               ((r_count[bus.push_vc] - count_width'(w_pop_hit[bus.push_vc])) != '0);
   end

   assign bus.push_ready     = !bus.free_list_empty;
   assign bus.alloc_enable   = w_push_acc;
   assign bus.free_enable    = w_pop_acc;
   assign bus.freed_slot     = w_pop_acc ? w_pop_head : '0;
   assign bus.vc_empty       = w_vc_empty;
   assign bus.pop_data       = r_pop_data;
   assign bus.pop_data_valid = r_pop_data_valid;

   // The tracker's full flag carries no action here.
   assign w_unused_ok = &{1'b0, bus.free_list_full};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int v = 0; v < num_vcs; v++) begin
            r_head[v]  <= '0;
            r_tail[v]  <= '0;
            r_count[v] <= '0;
         end
         r_pop_data       <= '0;
         r_pop_data_valid <= 1'b0;
      end else begin
         r_pop_data_valid <= w_pop_acc;
         if (w_pop_acc) begin
            r_pop_data <= r_data_ram[w_pop_head];
         end
         for (int v = 0; v < num_vcs; v++) begin
            r_count[v] <= r_count[v] + count_width'(w_push_hit[v]) - count_width'(w_pop_hit[v]);
            if (w_push_hit[v] && !w_link) begin
               r_head[v] <= bus.alloc_slot;
               r_tail[v] <= bus.alloc_slot;
            end else begin
               if (w_push_hit[v]) begin
                  r_tail[v] <= bus.alloc_slot;
               end
               if (w_pop_hit[v]) begin
                  r_head[v] <= r_next_ram[r_head[v]];
               end
            end
         end
      end
   end

   // Storage is left uninitialised; list state alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (w_push_acc) begin
         r_data_ram[bus.alloc_slot] <= bus.push_data;
         if (w_link) begin
            r_next_ram[r_tail[bus.push_vc]] <= bus.alloc_slot;
         end
      end
   end
endmodule

// File: tb/tb_shared_buffer_vc_lists.sv
// tb/tb_shared_buffer_vc_lists.sv - scoreboard bench with queue-based reference model and tracker model
module tb_shared_buffer_vc_lists;
   localparam int DEPTH = 32;
   localparam int W     = 64;
   localparam int NV    = 4;
   localparam int AW    = 5;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   shared_buffer_vc_lists_if #(.memory_bank_depth(DEPTH), .memory_bank_width(W), .num_vcs(NV)) bus ();

   shared_buffer_vc_lists #(.memory_bank_depth(DEPTH), .memory_bank_width(W), .num_vcs(NV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_pass  = 0;
   int n_total = 0;

   logic [W-1:0] mq_data [NV][$];
   int           mq_slot [NV][$];
   int           free_q[$];
   logic [W-1:0] sb_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic drive_tracker();
      bus.alloc_slot      = (free_q.size() != 0) ? AW'(free_q[0]) : '0;
      bus.free_list_empty = (free_q.size() == 0);
      bus.free_list_full  = (free_q.size() == DEPTH);
   endtask

   task automatic model_reset();
      for (int v = 0; v < NV; v++) begin
         mq_data[v].delete();
         mq_slot[v].delete();
      end
      sb_q.delete();
      free_q.delete();
      free_q.push_back(5);
      free_q.push_back(9);
      free_q.push_back(1);
      for (int i = 0; i < DEPTH; i++)
         if (i != 5 && i != 9 && i != 1) free_q.push_back(i);
      drive_tracker();
   endtask

   task automatic set_idle();
      bus.push_valid = 1'b0;
      bus.push_vc    = '0;
      bus.push_data  = '0;
      bus.pop_valid  = 1'b0;
      bus.pop_vc     = '0;
   endtask

   task automatic step(input bit pv, input int pvc, input logic [W-1:0] pd, input bit qv, input int qvc);
      bit            push_ok;
      bit            pop_ok;
      int            fslot;
      int            s;
      logic [NV-1:0] exp_empty;
      logic [W-1:0]  d;
      @(negedge clk);
      bus.push_valid = pv;
      bus.push_vc    = 2'(pvc);
      bus.push_data  = pd;
      bus.pop_valid  = qv;
      bus.pop_vc     = 2'(qvc);
      push_ok = pv && (free_q.size() != 0);
      pop_ok  = qv && (mq_data[qvc].size() != 0);
      fslot   = pop_ok ? mq_slot[qvc][0] : 0;
      for (int v = 0; v < NV; v++) exp_empty[v] = (mq_data[v].size() == 0);
      #1;
      check("push_ready",   64'(bus.push_ready),   64'(free_q.size() != 0));
      check("alloc_enable", 64'(bus.alloc_enable), 64'(push_ok));
      check("free_enable",  64'(bus.free_enable),  64'(pop_ok));
      check("freed_slot",   64'(bus.freed_slot),   64'(fslot));
      check("vc_empty",     64'(bus.vc_empty),     64'(exp_empty));
      if (pop_ok) sb_q.push_back(mq_data[qvc][0]);
      @(posedge clk);
      #1;
      if (pop_ok) begin
         d = mq_data[qvc].pop_front();
         s = mq_slot[qvc].pop_front();
      end
      if (push_ok) begin
         s = free_q.pop_front();
         mq_data[pvc].push_back(pd);
         mq_slot[pvc].push_back(s);
      end
      if (pop_ok) free_q.push_back(fslot);
      drive_tracker();
   endtask

   task automatic drain();
      for (int v = 0; v < NV; v++)
         while (mq_data[v].size() != 0) step(0, 0, '0, 1, v);
      step(0, 0, '0, 0, 0);
   endtask

   function automatic logic [W-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   initial begin : monitor
      logic [W-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (bus.pop_data_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_total++;
               $display("FAIL pop_data_unexpected: got valid data %0h expected no valid at %0t", bus.pop_data, $time);
            end else begin
               e = sb_q.pop_front();
               check("pop_data", bus.pop_data, e);
            end
         end
      end
   end

   initial begin : stim
      reset = 1'b0;
      set_idle();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_vc_empty",       64'(bus.vc_empty),       64'hf);
      check("rst_pop_data_valid", 64'(bus.pop_data_valid), 64'h0);
      check("rst_pop_data",       bus.pop_data,            64'h0);
      check("rst_alloc_enable",   64'(bus.alloc_enable),   64'h0);
      @(negedge clk);
      reset = 1'b1;

      step(0, 0, '0, 1, 0);

      step(1, 2, 64'hA, 0, 0);
      step(1, 2, 64'hB, 0, 0);
      step(1, 2, 64'hC, 0, 0);
      step(0, 0, '0, 1, 2);
      step(0, 0, '0, 1, 2);
      step(0, 0, '0, 1, 2);
      step(0, 0, '0, 0, 0);

      step(1, 0, 64'h1000, 0, 0);
      step(1, 1, 64'h2000, 0, 0);
      step(1, 0, 64'h1001, 0, 0);
      step(1, 1, 64'h2001, 0, 0);
      step(0, 0, '0, 1, 1);
      step(0, 0, '0, 1, 0);
      step(0, 0, '0, 1, 1);
      step(0, 0, '0, 1, 0);
      step(0, 0, '0, 0, 0);

      for (int i = 0; i < DEPTH; i++) step(1, $urandom_range(0, NV - 1), rnd64(), 0, 0);
      step(1, 0, rnd64(), 0, 0);
      for (int v = 0; v < NV; v++)
         if (mq_data[v].size() != 0 && free_q.size() == 0) step(0, 0, '0, 1, v);
      step(0, 0, '0, 0, 0);
      drain();

      step(1, 3, 64'hD0, 0, 0);
      step(1, 3, 64'hD1, 1, 3);
      step(0, 0, '0, 0, 0);
      step(0, 0, '0, 1, 3);
      step(0, 0, '0, 0, 0);

      for (int i = 0; i < 5; i++) step(1, i % NV, rnd64(), 0, 0);
      set_idle();
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("async_vc_empty",       64'(bus.vc_empty),       64'hf);
      check("async_pop_data_valid", 64'(bus.pop_data_valid), 64'h0);
      check("async_pop_data",       bus.pop_data,            64'h0);
      check("async_free_enable",    64'(bus.free_enable),    64'h0);
      check("async_freed_slot",     64'(bus.freed_slot),     64'h0);
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      step(1, 0, 64'hFEED_F00D, 0, 0);
      step(0, 0, '0, 1, 0);
      step(0, 0, '0, 0, 0);

      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 9) < 7, $urandom_range(0, NV - 1), rnd64(),
              $urandom_range(0, 9) < 6, $urandom_range(0, NV - 1));
      drain();
      step(0, 0, '0, 0, 0);
      check("scoreboard_drained", 64'(sb_q.size()), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
